crypt_sequencer: RTL and testbench
==================================

# crypt_sequencer

Sequencing controller for the serial XOR-encryption datapath. It accepts one framed serial transaction on a single data pin and steers the first KEY_SIZE bits to the key deserializer and the next MSG_SIZE bits to the message deserializer. It then triggers encryption, launches the ciphertext serializer and reports completion or timeout. It sits between the top-level `ui_in` pins and the deserializer/xor/serializer chain, and replaces the host hand-driving separate key and message flags.

## Interface
- `MSG_SIZE`, 64, message/ciphertext length in bits.
- `KEY_SIZE`, 8, key length in bits.
- `TIMEOUT`, 255, maximum enabled cycles spent waiting in ENCRYPT or in either SERIALIZE phase; minimum 1.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable; when low, all state, counters and outputs hold.
- `iStart`  in  1  begin a transaction; sampled only in IDLE.
- `iAbort`  in  1  return to IDLE on the next edge, from any state.
- `iValid`  in  1  `iSerial` carries a valid bit this cycle.
- `iSerial`  in  1  serial key-then-message bit stream, MSB first.
- `iEnc_done`  in  1  encryption-status level from the xor stage.
- `iSer_busy`  in  1  data-flag level from the ciphertext serializer.
- `oData`  out  1  registered copy of `iSerial`, fed to both deserializers.
- `oKey_flag`  out  1  load flag for the key deserializer.
- `oMsg_flag`  out  1  load flag for the message deserializer.
- `oEnc_start`  out  1  one-cycle encryption trigger.
- `oSer_start`  out  1  one-cycle serializer trigger.
- `oBusy`  out  1  high in every state except IDLE.
- `oDone`  out  1  one-cycle pulse on successful completion.
- `oError`  out  1  sticky timeout flag; cleared by `iStart` accepted in IDLE, or by reset.
- `oState`  out  3  current state encoding, for the debug shift register.

## Operation
- States and encodings: IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, SER_WAIT=4, SER_RUN=5, DONE=6, ERROR=7.
- **IDLE.** On `iStart`, clear the bit counter and `oError`, then go to LOAD_KEY.
- **LOAD_KEY.**
  - Each cycle with `iValid` high: `oKey_flag`=1, `oData`=`iSerial`, bit counter +1.
  - After bit KEY_SIZE: clear the counter and go to LOAD_MSG.
- **LOAD_MSG.**
  - Each `iValid` cycle: `oMsg_flag`=1, `oData`=`iSerial`, counter +1.
  - After bit MSG_SIZE: pulse `oEnc_start` and go to ENCRYPT.
- **Stalls.** `iValid` low in either load state means the flag is 0, the counter holds, and there is no timeout.
- **ENCRYPT.**
  - Wait for `iEnc_done`=1, then pulse `oSer_start` and go to SER_WAIT.
  - If TIMEOUT cycles pass without it, go to ERROR.
- **SER_WAIT.** Wait for `iSer_busy`=1, then go to SER_RUN; TIMEOUT without it goes to ERROR.
- **SER_RUN.** Wait for `iSer_busy`=0, then go to DONE; MSG_SIZE+TIMEOUT cycles without it goes to ERROR.
- **DONE.** `oDone`=1 for one cycle, then go to IDLE.
- **ERROR.** Set `oError`, then go to IDLE after one cycle.
- **Abort.** `iAbort` has priority over every other transition, including `iStart` in IDLE and a counter completing on the same cycle. The next state is IDLE, counters clear, pulse outputs go 0, and `oError` is unchanged.
- **Start outside IDLE.** `iStart` in any state other than IDLE is ignored.
- **Counter widths.** Bit counter is `$clog2(MSG_SIZE)+1` bits; wait counter is `$clog2(MSG_SIZE+TIMEOUT)+1` bits; neither counter wraps.

## Timing
- **Reset.** State=IDLE, both counters=0, all outputs 0 (`oState`=0).
- All outputs are registered.
- **Load latency.** `oData` and its flag appear one cycle after the corresponding `iValid`/`iSerial` sample.
- **Key-to-message boundary.** The last key flag and the first message flag may be on consecutive cycles with no gap.
- **Encryption trigger.** `oEnc_start` is asserted in the same cycle as the final `oMsg_flag`.
- **Wait counter.** Reset on entry to ENCRYPT, SER_WAIT and SER_RUN; increments only when `ena` is high.
- **`ena` low.** Freezes the FSM mid-operation. Input bits presented while `ena` is low are dropped and not counted.
- **Minimum transaction.** KEY_SIZE+MSG_SIZE valid cycles, plus encryption latency, plus serializer duration, plus 2.

## Structure
- Shared package `crypt_seq_pkg` holds:
  - the state encoding constants (3-bit, values above);
  - `KEY_SIZE`/`MSG_SIZE` defaults;
  - `TIMEOUT`.
- One natural sub-module, `seq_timer`:
  - loadable down-counter with clear, enable and `expired` output;
  - used for the ENCRYPT and SER_* timeouts.
- The bit counter and FSM stay in `crypt_sequencer`.

## Test plan
- **Nominal.** `iStart`; key 8'hA5 then a 64-bit message, `iValid` continuous; `iEnc_done` 3 cycles after `oEnc_start`; serializer busy for 64 cycles.
  - Required: exactly 8 `oKey_flag` and 64 `oMsg_flag` cycles with matching `oData`; one `oEnc_start`, one `oSer_start`, one `oDone`; `oError`=0.
- **Stalled input.** `iValid` toggling 1,0,1,0 through the load.
  - Required: flag count still 8+64, counter holds during gaps, no timeout.
- **Encryption timeout.** `iEnc_done` held 0.
  - Required: ERROR entered 255 cycles after ENCRYPT entry; `oError`=1 sticky; IDLE next cycle; the next accepted `iStart` clears `oError`.
- **Abort.** `iAbort` asserted at message bit 30, then a new full transaction.
  - Required: IDLE next cycle, flags 0, no `oDone`; the second run completes normally.
- **Priority.** `iStart` and `iAbort` together in IDLE → remain IDLE. `iStart` during LOAD_MSG → ignored, counters unaffected.
- **Reset mid-run and `ena`.** `rst_n` low during SER_RUN → all outputs 0 immediately. `ena` low for 10 cycles in ENCRYPT → wait counter frozen, timeout deadline extended by 10 cycles.

Source files
------------

// File: rtl/crypt_seq_pkg.sv
// rtl/crypt_seq_pkg.sv - shared state encoding and default sizes for crypt_sequencer
package crypt_seq_pkg;

    localparam int MSG_SIZE_DEF = 64;
    localparam int KEY_SIZE_DEF = 8;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_KEY = 3'd1,
        ST_LOAD_MSG = 3'd2,
        ST_ENCRYPT  = 3'd3,
        ST_SER_WAIT = 3'd4,
        ST_SER_RUN  = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } state_e;

    // States whose dwell time is bounded by the timeout counter.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_ENCRYPT) || (s == ST_SER_WAIT) || (s == ST_SER_RUN);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable timeout down-counter with clear, enable and expired flag
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means the current enabled cycle is the last one allowed.
    assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/crypt_sequencer.sv
// rtl/crypt_sequencer.sv - steers a framed key+message bit stream and sequences encrypt/serialize
module crypt_sequencer
    import crypt_seq_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int KEY_SIZE = KEY_SIZE_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       iStart,
    input  logic       iAbort,
    input  logic       iValid,
    input  logic       iSerial,
    input  logic       iEnc_done,
    input  logic       iSer_busy,
    output logic       oData,
    output logic       oKey_flag,
    output logic       oMsg_flag,
    output logic       oEnc_start,
    output logic       oSer_start,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic [2:0] oState
);

    localparam int BW = $clog2(MSG_SIZE) + 1;
    localparam int TW = $clog2(MSG_SIZE + TIMEOUT) + 1;
    localparam logic [BW-1:0] KEY_LAST   = BW'(KEY_SIZE - 1);
    localparam logic [BW-1:0] MSG_LAST   = BW'(MSG_SIZE - 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0] RUN_LIMIT  = TW'(MSG_SIZE + TIMEOUT);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          data_q, data_d;
    logic          key_flag_q, key_flag_d;
    logic          msg_flag_q, msg_flag_d;
    logic          enc_start_q, enc_start_d;
    logic          ser_start_q, ser_start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          tmr_clear, tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0] tmr_load_val;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        key_flag_d  = 1'b0;
        msg_flag_d  = 1'b0;
        enc_start_d = 1'b0;
        ser_start_d = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;

        if (iAbort) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        bit_cnt_d = '0;
                        error_d   = 1'b0;
                        state_d   = ST_LOAD_KEY;
                    end
                end
                ST_LOAD_KEY: begin
                    if (iValid) begin
                        key_flag_d = 1'b1;
                        data_d     = iSerial;
                        if (bit_cnt_q == KEY_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_LOAD_MSG;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_LOAD_MSG: begin
                    if (iValid) begin
                        msg_flag_d = 1'b1;
                        data_d     = iSerial;
                        if (bit_cnt_q == MSG_LAST) begin
                            bit_cnt_d   = '0;
                            enc_start_d = 1'b1;
                            state_d     = ST_ENCRYPT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_ENCRYPT: begin
                    if (iEnc_done) begin
                        ser_start_d = 1'b1;
                        state_d     = ST_SER_WAIT;
                    end else if (tmr_expired) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SER_WAIT: begin
                    if (iSer_busy) begin
                        state_d = ST_SER_RUN;
                    end else if (tmr_expired) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SER_RUN: begin
                    if (!iSer_busy) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (tmr_expired) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERROR: state_d = ST_IDLE;
            endcase
            if (state_d == ST_ERROR) begin
                error_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // The timer is reloaded on every wait-state entry, so each phase gets its own deadline.
    always_comb begin
        tmr_en       = ena && is_wait_state(state_q);
        tmr_load     = ena && is_wait_state(state_d) && (state_d != state_q);
        tmr_clear    = ena && !is_wait_state(state_d);
        tmr_load_val = (state_d == ST_SER_RUN) ? RUN_LIMIT : WAIT_LIMIT;
    end

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            data_q      <= 1'b0;
            key_flag_q  <= 1'b0;
            msg_flag_q  <= 1'b0;
            enc_start_q <= 1'b0;
            ser_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            key_flag_q  <= key_flag_d;
            msg_flag_q  <= msg_flag_d;
            enc_start_q <= enc_start_d;
            ser_start_q <= ser_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign oData      = data_q;
    assign oKey_flag  = key_flag_q;
    assign oMsg_flag  = msg_flag_q;
    assign oEnc_start = enc_start_q;
    assign oSer_start = ser_start_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oError     = error_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_crypt_sequencer.sv
// tb/tb_crypt_sequencer.sv - table-driven and randomized transaction-level bench for crypt_sequencer
module tb_crypt_sequencer;

    localparam int KS = 8;
    localparam int MS = 64;
    localparam int TO = 255;
    localparam int NB = KS + MS;

    typedef struct {
        int vmode, spam, lat, w, len, abort_at, gap, rst;
        int kf, mf, enc, ser, done, err_st, err_off;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, ena = 1'b0;
    logic       iStart = 1'b0, iAbort = 1'b0, iValid = 1'b0, iSerial = 1'b0;
    logic       iEnc_done = 1'b0, iSer_busy = 1'b0;
    logic       oData, oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oDone, oError;
    logic [2:0] oState;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0]  r_key;
    logic [63:0] r_msg;
    int r_kf, r_mf, r_enc, r_ser, r_done, r_err_state, r_err_off, r_done_edge, r_e_pred;
    int r_enc_ok, r_rst_zero, r_abort_ok, r_timeout;

    always #5 clk = ~clk;

    crypt_sequencer #(.MSG_SIZE(MS), .KEY_SIZE(KS), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .iStart     (iStart),
        .iAbort     (iAbort),
        .iValid     (iValid),
        .iSerial    (iSerial),
        .iEnc_done  (iEnc_done),
        .iSer_busy  (iSer_busy),
        .oData      (oData),
        .oKey_flag  (oKey_flag),
        .oMsg_flag  (oMsg_flag),
        .oEnc_start (oEnc_start),
        .oSer_start (oSer_start),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oError     (oError),
        .oState     (oState)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [10:0] outs();
        return {oData, oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oDone, oError, oState};
    endfunction

    // Drives one transaction with simple xor-stage and serializer responders, recording what comes out.
    task automatic run_txn(input vec_t v, input logic [7:0] key, input logic [63:0] msg);
        logic [NB-1:0] bits;
        int bi, enc_edge, ser_edge, st_prev, st_now;
        int entry [8];
        bit v_now, abort_now, finished;
        bits = {key, msg};
        bi = 0; enc_edge = -1; ser_edge = -1; finished = 0; v_now = 0;
        foreach (entry[s]) entry[s] = -1;
        r_key = '0; r_msg = '0; r_kf = 0; r_mf = 0; r_enc = 0; r_ser = 0; r_done = 0;
        r_err_state = 0; r_err_off = 0; r_done_edge = -1; r_e_pred = -1;
        r_enc_ok = 0; r_rst_zero = 0; r_abort_ok = 0; r_timeout = 0;

        iStart = 1'b1;
        tick();
        check("start_accept", oState, 1);
        check("err_clear_on_start", oError, 0);
        iStart = (v.spam != 0);
        entry[1] = cyc;
        st_prev = 1;
        for (int k = 0; k < 3000 && !finished; k++) begin
            iAbort = 1'b0; iValid = 1'b0; iSerial = 1'b0;
            if (bi < NB) begin
                case (v.vmode)
                    0:       v_now = 1'b1;
                    1:       v_now = (k % 2 == 0);
                    default: v_now = ($urandom_range(0, 3) != 0);
                endcase
                iValid  = v_now;
                iSerial = v_now ? bits[NB-1-bi] : 1'($urandom);
                if (v_now && bi == v.abort_at) iAbort = 1'b1;
                if (v_now) begin
                    bi++;
                    if (bi == NB) r_e_pred = cyc + 1;
                end
            end
            abort_now = iAbort;
            iEnc_done = (enc_edge >= 0) && (cyc >= enc_edge + v.lat);
            iSer_busy = (ser_edge >= 0) && (cyc >= ser_edge + v.w) && (cyc < ser_edge + v.w + v.len);
            ena = !(v.gap > 0 && entry[3] >= 0 && cyc >= entry[3] + 5 && cyc < entry[3] + 5 + v.gap);
            tick();
            st_now = int'(oState);
            if (oKey_flag) begin r_key = {r_key[6:0], oData}; r_kf++; end
            if (oMsg_flag) begin r_msg = {r_msg[62:0], oData}; r_mf++; end
            if (oEnc_start) begin
                r_enc++; enc_edge = cyc;
                r_enc_ok = (oMsg_flag && r_mf == MS) ? 1 : 0;
            end
            if (oSer_start) begin r_ser++; ser_edge = cyc; end
            if (oDone) begin r_done++; r_done_edge = cyc; end
            if (entry[st_now] < 0) entry[st_now] = cyc;
            if (st_now == 7 && st_prev != 7) begin
                r_err_state = st_prev;
                r_err_off = cyc - entry[st_prev];
            end
            if (abort_now) begin
                r_abort_ok = (st_now == 0 && !oKey_flag && !oMsg_flag && !oEnc_start && !oBusy && !oDone) ? 1 : 0;
                finished = 1;
            end else if (v.rst != 0 && st_now == 5) begin
                #2 rst_n = 1'b0;
                #1 r_rst_zero = (outs() == '0) ? 1 : 0;
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1;
            end else if (st_now == 0) begin
                finished = 1;
            end
            st_prev = st_now;
        end
        r_timeout = finished ? 0 : 1;
        iStart = 1'b0; iAbort = 1'b0; iValid = 1'b0; iSerial = 1'b0;
        iEnc_done = 1'b0; iSer_busy = 1'b0; ena = 1'b1;
    endtask

    task automatic compare_txn(input string tag, input vec_t v, input logic [7:0] key, input logic [63:0] msg);
        check({tag, " ended_in_budget"}, r_timeout, 0);
        check({tag, " key_flags"}, r_kf, v.kf);
        check({tag, " msg_flags"}, r_mf, v.mf);
        check({tag, " enc_starts"}, r_enc, v.enc);
        check({tag, " ser_starts"}, r_ser, v.ser);
        check({tag, " dones"}, r_done, v.done);
        check({tag, " timeout_state"}, r_err_state, v.err_st);
        if (v.err_st != 0) begin
            check({tag, " timeout_cycles"}, r_err_off, v.err_off);
            check({tag, " error_sticky"}, oError, 1);
        end else begin
            check({tag, " error_low"}, oError, 0);
        end
        if (v.done != 0) begin
            check({tag, " key_data"}, r_key, key);
            check({tag, " msg_data"}, r_msg, msg);
            check({tag, " enc_with_last_flag"}, r_enc_ok, 1);
            check({tag, " done_cycle"}, r_done_edge, r_e_pred + v.lat + v.w + v.len + 2);
        end
        if (v.abort_at >= 0) check({tag, " abort_to_idle"}, r_abort_ok, 1);
        if (v.rst != 0) check({tag, " reset_clears_outputs"}, r_rst_zero, 1);
        check({tag, " back_in_idle"}, oState, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [13];
        vec_t rv;
        logic [7:0] rk;
        logic [63:0] rm;
        bit did_prio;
        string tag;

        //            vmode spam lat  w    len  abort gap rst  kf mf enc ser done err_st err_off
        vecs[0]  = '{0, 0,   3,   0,   64,  -1,   0,  0,   8, 64, 1,  1,  1,   0,     0};
        vecs[1]  = '{1, 1,   3,   0,   64,  -1,   0,  0,   8, 64, 1,  1,  1,   0,     0};
        vecs[2]  = '{0, 0,   254, 0,   64,  -1,   0,  0,   8, 64, 1,  1,  1,   0,     0};
        vecs[3]  = '{0, 0,   255, 0,   64,  -1,   0,  0,   8, 64, 1,  0,  0,   3,     255};
        vecs[4]  = '{0, 0,   0,   254, 1,   -1,   0,  0,   8, 64, 1,  1,  1,   0,     0};
        vecs[5]  = '{0, 0,   0,   255, 1,   -1,   0,  0,   8, 64, 1,  1,  0,   4,     255};
        vecs[6]  = '{0, 0,   0,   0,   319, -1,   0,  0,   8, 64, 1,  1,  1,   0,     0};
        vecs[7]  = '{0, 0,   0,   0,   320, -1,   0,  0,   8, 64, 1,  1,  0,   5,     319};
        vecs[8]  = '{0, 0,   3,   0,   64,  38,   0,  0,   8, 30, 0,  0,  0,   0,     0};
        vecs[9]  = '{0, 0,   3,   0,   64,  7,    0,  0,   7, 0,  0,  0,  0,   0,     0};
        vecs[10] = '{0, 0,   3,   0,   64,  71,   0,  0,   8, 63, 0,  0,  0,   0,     0};
        vecs[11] = '{0, 0,   400, 0,   64,  -1,   10, 0,   8, 64, 1,  0,  0,   3,     265};
        vecs[12] = '{0, 0,   3,   0,   64,  -1,   0,  1,   8, 64, 1,  1,  0,   0,     0};
        did_prio = 0;

        rst_n = 1'b0; ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), '0);
        check("reset_state", oState, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", {oBusy, oState}, 0);

        for (int i = 0; i < 13; i++) begin
            rk = (i == 0) ? 8'hA5 : 8'($urandom);
            rm = (i == 0) ? 64'h0123_4567_89AB_CDEF : {$urandom, $urandom};
            run_txn(vecs[i], rk, rm);
            tag = $sformatf("vec%0d", i);
            compare_txn(tag, vecs[i], rk, rm);
            if (vecs[i].err_st != 0 && !did_prio) begin
                did_prio = 1;
                iStart = 1'b1; iAbort = 1'b1;
                tick();
                check("start_abort_idle_state", oState, 0);
                check("start_abort_keeps_error", oError, 1);
                iStart = 1'b0; iAbort = 1'b0;
            end
            tick();
        end

        for (int t = 0; t < 8; t++) begin
            rv = '{2, 0, 0, 0, 1, -1, 0, 0, 8, 64, 1, 1, 1, 0, 0};
            rv.lat = $urandom_range(0, 20);
            rv.w   = $urandom_range(0, 5);
            rv.len = $urandom_range(1, 100);
            rk = 8'($urandom);
            rm = {$urandom, $urandom};
            run_txn(rv, rk, rm);
            tag = $sformatf("rand%0d", t);
            compare_txn(tag, rv, rk, rm);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
